load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Multi-cycle load/store unit for the next core generation. It replaces the combinational single-cycle memory access path with a request/grant/response handshake to data memory, and it generalises the data width via XLEN. It sits between the decode/execute stage and data memory. It computes the effective address, generates byte enables and lane-shifted write data, and sign/zero-extends load data. It also reports misaligned, illegal and timed-out accesses instead of silently performing them.

Parameters:
XLEN, 32, data/register width; legal values 32 or 64.
ADDR_W, 32, memory address width; must be >= 3.
TIMEOUT, 15, max cycles in WAIT without mem_rvalid before a fault; must be >= 1.

Ports:
clk  in  1  clock
nreset  in  1  synchronous active-low reset
req_valid  in  1  execute stage presents a memory op
req_ready  out  1  unit idle and able to accept
req_store  in  1  1 = store, 0 = load
req_funct3  in  3  RV funct3: 000 B, 001 H, 010 W, 011 D (XLEN=64 only), 100 BU, 101 HU, 110 WU (XLEN=64 only)
req_base  in  XLEN  rs1 value
req_offset  in  12  signed immediate
req_wdata  in  XLEN  rs2 value
req_rd  in  5  destination register tag
mem_req  out  1  memory request
mem_gnt  in  1  memory accepts request this cycle
mem_we  out  1  write enable
mem_addr  out  ADDR_W  aligned to XLEN/8 (low log2(XLEN/8) bits zero)
mem_be  out  XLEN/8  byte enables
mem_wdata  out  XLEN  lane-shifted write data
mem_rvalid  in  1  read data valid
mem_rdata  in  XLEN  read data
rsp_valid  out  1  one-cycle completion pulse
rsp_rd  out  5  tag of completed op
rsp_data  out  XLEN  extended load result (0 for stores/errors)
rsp_we  out  1  write rsp_data to rd (successful load with rd != 0)
rsp_err  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout

Behaviour:
- Reset (nreset low at posedge): state IDLE, timeout counter 0. All outputs 0 except req_ready = 1. Reset mid-transaction abandons it and produces no rsp_valid.
- Effective address: EA = req_base + sign_extend(req_offset), truncated to ADDR_W. Lane offset is the low log2(XLEN/8) bits of EA.
- States: IDLE, REQ, WAIT, RESP.
- IDLE: req_ready = 1. On req_valid, latch all req_* inputs.
  - If funct3 is illegal for XLEN or req_store with funct3 >= 100, go to RESP with err 10.
  - Else if EA is not aligned to the access size, go to RESP with err 01.
  - Else go to REQ.
  - Errors never assert mem_req.
- REQ: mem_req = 1, mem_we = store. mem_addr, mem_be and mem_wdata are held stable until mem_gnt.
  - On gnt, a store goes to RESP and a load goes to WAIT (counter cleared).
  - No gnt means the unit stays in REQ indefinitely.
- WAIT: counter increments each cycle. On mem_rvalid, capture the selected lanes and go to RESP. A rvalid in the same cycle the counter reaches TIMEOUT counts as success. When the counter reaches TIMEOUT without rvalid, go to RESP with err 11.
- RESP: rsp_valid = 1 for exactly one cycle, then return to IDLE. req_ready = 0 in REQ, WAIT and RESP. There is no response backpressure.
- Byte enables: a size of 1/2/4/8 bytes gives a mask of 1/3/F/FF shifted left by the lane offset.
- Store data: the low size bytes of req_wdata are shifted to the lane offset. Other bytes are don't-care but driven 0.
- Load data: mem_rdata is shifted right by lane offset*8 and truncated to size. Signed funct3 sign-extends to XLEN; the U variants zero-extend.
- Minimum latency, with accept in cycle 0: store rsp_valid in cycle 2 (gnt in cycle 1); load rsp_valid in cycle 3 (gnt in cycle 1, rvalid in cycle 2). An error response comes in cycle 1.
- rsp_we = 1 only for err 00, load, and rd != 0.
- mem_rvalid outside WAIT and mem_gnt outside REQ are ignored.

Test Plan:
- Load byte: XLEN=32, base=0x100, offset=0x003, funct3=000, gnt in cycle 1, rvalid in cycle 2 with rdata=0x80FF_1234. Required: mem_addr=0x100, mem_be=1000, rsp_data=0xFFFF_FF80, rsp_we=1, rsp_valid in cycle 3.
- Store halfword: base=0x200, offset=-2 (0xFFE), funct3=001, wdata=0xDEAD_BEEF. Required: mem_addr=0x1FC, mem_be=1100, mem_wdata[31:16]=0xBEEF, mem_we=1, rsp_valid with err 00 in the cycle after gnt.
- Misaligned word: base=0x101, funct3=010. Required: mem_req never asserted, rsp_valid in cycle 1, err=01, rsp_we=0.
- Timeout: TIMEOUT=4, load granted, rvalid never asserted. Required: rsp_valid 5 cycles after gnt with err=11. A separate run with rvalid in the 4th WAIT cycle must complete with err=00.
- Backpressure and reset: hold mem_gnt=0 for 10 cycles. Required: mem_req, mem_addr and mem_be stay stable and req_ready=0. Then drop nreset for one cycle. Required: IDLE, req_ready=1, no rsp_valid.
- XLEN=64, LWU: EA=0x1004, rdata=0x8765_4321_0000_0000. Required: mem_be=0xF0, rsp_data=0x0000_0000_8765_4321. funct3=011 with XLEN=32 gives err=10.

Source files
------------

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: computes the effective address and talks to data memory over a
// req/gnt/rvalid handshake. Misaligned, illegal and timed-out accesses come back as error codes.
module load_store_unit #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                nreset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_store,
   input  logic [2:0]          req_funct3,
   input  logic [XLEN-1:0]     req_base,
   input  logic [11:0]         req_offset,
   input  logic [XLEN-1:0]     req_wdata,
   input  logic [4:0]          req_rd,
   output logic                mem_req,
   input  logic                mem_gnt,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [XLEN/8-1:0]   mem_be,
   output logic [XLEN-1:0]     mem_wdata,
   input  logic                mem_rvalid,
   input  logic [XLEN-1:0]     mem_rdata,
   output logic                rsp_valid,
   output logic [4:0]          rsp_rd,
   output logic [XLEN-1:0]     rsp_data,
   output logic                rsp_we,
   output logic [1:0]          rsp_err
);

   localparam int unsigned NB    = XLEN / 8;
   localparam int unsigned LaneW = $clog2(NB);
   localparam int unsigned CntW  = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

   state_e              state_q, state_d;
   logic                store_q, store_d;
   logic [2:0]          funct3_q, funct3_d;
   logic [4:0]          rd_q, rd_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [XLEN-1:0]     wdata_q, wdata_d;
   logic [XLEN-1:0]     data_q, data_d;
   logic [1:0]          err_q, err_d;
   logic [CntW-1:0]     cnt_q, cnt_d;

   logic [XLEN-1:0]     ea_x;
   logic [ADDR_W-1:0]   ea;
   logic                illegal, misaligned;
   logic [LaneW-1:0]    lane;
   logic [7:0]          size_mask;
   logic [NB-1:0]       be_full;
   logic [XLEN-1:0]     wdata_sh, wdata_lane, rdata_sh, load_ext;
   logic                sign;
   int                  nbits;

   assign ea_x = req_base + {{(XLEN-12){req_offset[11]}}, req_offset};
   assign ea   = ADDR_W'(ea_x);

   always_comb begin
      illegal = (req_funct3 == 3'b111) || (req_store && req_funct3[2]) ||
                ((XLEN == 32) && (req_funct3 == 3'b011 || req_funct3 == 3'b110));
      unique case (req_funct3[1:0])
         2'd0:    misaligned = 1'b0;
         2'd1:    misaligned = ea[0];
         2'd2:    misaligned = |ea[1:0];
         default: misaligned = |ea[2:0];
      endcase
   end

   // Lane steering for the latched operation.
   always_comb begin
      lane     = addr_q[LaneW-1:0];
      nbits    = 8 << funct3_q[1:0];
      unique case (funct3_q[1:0])
         2'd0:    begin size_mask = 8'h01; sign = rdata_sh[7];  end
         2'd1:    begin size_mask = 8'h03; sign = rdata_sh[15]; end
         2'd2:    begin size_mask = 8'h0f; sign = rdata_sh[31]; end
         default: begin size_mask = 8'hff; sign = rdata_sh[XLEN-1]; end
      endcase
      be_full    = NB'(size_mask) << lane;
      wdata_sh   = wdata_q << {lane, 3'b000};
      rdata_sh   = mem_rdata >> {lane, 3'b000};
      wdata_lane = '0;
      for (int i = 0; i < int'(NB); i++) begin
         wdata_lane[i*8 +: 8] = be_full[i] ? wdata_sh[i*8 +: 8] : 8'h00;
      end
      load_ext = '0;
      for (int i = 0; i < int'(XLEN); i++) begin
         load_ext[i] = (i < nbits) ? rdata_sh[i] : (sign & ~funct3_q[2]);
      end
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q  <= StIdle;
         store_q  <= 1'b0;
         funct3_q <= '0;
         rd_q     <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         data_q   <= '0;
         err_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         store_q  <= store_d;
         funct3_q <= funct3_d;
         rd_q     <= rd_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         data_q   <= data_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      store_d  = store_q;
      funct3_d = funct3_q;
      rd_d     = rd_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      data_d   = data_q;
      err_d    = err_q;
      cnt_d    = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               store_d  = req_store;
               funct3_d = req_funct3;
               rd_d     = req_rd;
               addr_d   = ea;
               wdata_d  = req_wdata;
               data_d   = '0;
               if (illegal) begin
                  err_d   = 2'b10;
                  state_d = StResp;
               end else if (misaligned) begin
                  err_d   = 2'b01;
                  state_d = StResp;
               end else begin
                  err_d   = 2'b00;
                  state_d = StReq;
               end
            end
         end
         StReq: begin
            if (mem_gnt) begin
               cnt_d   = '0;
               state_d = store_q ? StResp : StWait;
            end
         end
         StWait: begin
            cnt_d = cnt_q + 1'b1;
            // A late rvalid on the final counted cycle still wins over the timeout.
            if (mem_rvalid) begin
               data_d  = load_ext;
               state_d = StResp;
            end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
               err_d   = 2'b11;
               state_d = StResp;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      req_ready = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_be    = '0;
      mem_wdata = '0;
      rsp_valid = 1'b0;
      rsp_rd    = '0;
      rsp_data  = '0;
      rsp_we    = 1'b0;
      rsp_err   = '0;
      unique case (state_q)
         StIdle: req_ready = 1'b1;
         StReq: begin
            mem_req   = 1'b1;
            mem_we    = store_q;
            mem_addr  = addr_q & ~ADDR_W'(NB - 1);
            mem_be    = be_full;
            mem_wdata = wdata_lane;
         end
         StResp: begin
            rsp_valid = 1'b1;
            rsp_rd    = rd_q;
            rsp_data  = data_q;
            rsp_err   = err_q;
            rsp_we    = (err_q == 2'b00) && !store_q && (rd_q != 5'd0);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised scoreboard bench: a 32-bit unit (TIMEOUT=4) and a 64-bit unit are exercised in turn
// against an arithmetic reference model.
module tb_load_store_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        nrst_a, nrst_b, phase;
   logic        req_valid, req_store, mem_gnt, mem_rvalid;
   logic [2:0]  req_funct3;
   logic [11:0] req_offset;
   logic [4:0]  req_rd;
   logic [63:0] req_base, req_wdata, mem_rdata;
   int          xlen_cur, tmo_cur;

   logic        a_req_ready, a_mem_req, a_mem_we, a_rsp_valid, a_rsp_we;
   logic [31:0] a_mem_addr, a_mem_wdata, a_rsp_data;
   logic [3:0]  a_mem_be;
   logic [4:0]  a_rsp_rd;
   logic [1:0]  a_rsp_err;
   logic        b_req_ready, b_mem_req, b_mem_we, b_rsp_valid, b_rsp_we;
   logic [31:0] b_mem_addr;
   logic [63:0] b_mem_wdata, b_rsp_data;
   logic [7:0]  b_mem_be;
   logic [4:0]  b_rsp_rd;
   logic [1:0]  b_rsp_err;

   logic        m_req_ready, m_mem_req, m_mem_we, m_rsp_valid, m_rsp_we;
   logic [31:0] m_mem_addr;
   logic [63:0] m_mem_wdata, m_rsp_data;
   logic [7:0]  m_mem_be;
   logic [4:0]  m_rsp_rd;
   logic [1:0]  m_rsp_err;

   load_store_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) dut_a (
      .clk(clk), .nreset(nrst_a), .req_valid(req_valid), .req_ready(a_req_ready),
      .req_store(req_store), .req_funct3(req_funct3), .req_base(req_base[31:0]),
      .req_offset(req_offset), .req_wdata(req_wdata[31:0]), .req_rd(req_rd),
      .mem_req(a_mem_req), .mem_gnt(mem_gnt), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
      .mem_be(a_mem_be), .mem_wdata(a_mem_wdata), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata[31:0]), .rsp_valid(a_rsp_valid), .rsp_rd(a_rsp_rd),
      .rsp_data(a_rsp_data), .rsp_we(a_rsp_we), .rsp_err(a_rsp_err)
   );

   load_store_unit #(.XLEN(64), .ADDR_W(32), .TIMEOUT(15)) dut_b (
      .clk(clk), .nreset(nrst_b), .req_valid(req_valid), .req_ready(b_req_ready),
      .req_store(req_store), .req_funct3(req_funct3), .req_base(req_base),
      .req_offset(req_offset), .req_wdata(req_wdata), .req_rd(req_rd),
      .mem_req(b_mem_req), .mem_gnt(mem_gnt), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
      .mem_be(b_mem_be), .mem_wdata(b_mem_wdata), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .rsp_valid(b_rsp_valid), .rsp_rd(b_rsp_rd),
      .rsp_data(b_rsp_data), .rsp_we(b_rsp_we), .rsp_err(b_rsp_err)
   );

   always_comb begin
      if (!phase) begin
         m_req_ready = a_req_ready; m_mem_req = a_mem_req; m_mem_we = a_mem_we;
         m_mem_addr = a_mem_addr; m_mem_be = {4'b0, a_mem_be}; m_mem_wdata = {32'b0, a_mem_wdata};
         m_rsp_valid = a_rsp_valid; m_rsp_rd = a_rsp_rd; m_rsp_data = {32'b0, a_rsp_data};
         m_rsp_we = a_rsp_we; m_rsp_err = a_rsp_err;
      end else begin
         m_req_ready = b_req_ready; m_mem_req = b_mem_req; m_mem_we = b_mem_we;
         m_mem_addr = b_mem_addr; m_mem_be = b_mem_be; m_mem_wdata = b_mem_wdata;
         m_rsp_valid = b_rsp_valid; m_rsp_rd = b_rsp_rd; m_rsp_data = b_rsp_data;
         m_rsp_we = b_rsp_we; m_rsp_err = b_rsp_err;
      end
   end

   logic [63:0] cyc = 64'd0;
   always @(posedge clk) cyc <= cyc + 64'd1;

   typedef struct packed {
      logic [1:0]  err;
      logic [63:0] data;
      logic        we;
      logic [4:0]  rd;
      logic [63:0] cyc;
   } rsp_t;

   rsp_t exp_q[$];
   rsp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic push_rsp(input logic [1:0] err, input logic [63:0] data, input logic we,
                           input logic [4:0] rd, input logic [63:0] at);
      rsp_t r;
      r.err = err; r.data = data; r.we = we; r.rd = rd; r.cyc = at;
      exp_q.push_back(r);
   endtask

   // Reference model: the access expressed as plain byte arithmetic.
   function automatic void model(input int xlen, input bit st, input logic [2:0] f3,
                                 input logic [63:0] base, input logic [11:0] off,
                                 input logic [63:0] wd, input logic [63:0] rdata,
                                 output logic [1:0] err, output logic [31:0] addr,
                                 output logic [7:0] be, output logic [63:0] wexp,
                                 output logic [63:0] dexp);
      logic [63:0] b, ea64, mask, v, rd_in;
      int size, lane;
      b     = (xlen == 32) ? {32'd0, base[31:0]} : base;
      rd_in = (xlen == 32) ? {32'd0, rdata[31:0]} : rdata;
      ea64  = b + {{52{off[11]}}, off};
      size  = 1 << f3[1:0];
      lane  = int'(ea64 % 64'(xlen / 8));
      if (f3 == 3'd7 || (st && f3 >= 3'd4) || (xlen == 32 && (f3 == 3'd3 || f3 == 3'd6)))
         err = 2'b10;
      else if (ea64 % 64'(size) != 64'd0)
         err = 2'b01;
      else
         err = 2'b00;
      addr = ea64[31:0] - 32'(lane);
      be   = 8'(((1 << size) - 1) << lane);
      mask = (size == 8) ? '1 : (64'd1 << (8 * size)) - 64'd1;
      wexp = (wd & mask) << (8 * lane);
      v    = (rd_in >> (8 * lane)) & mask;
      if (!f3[2] && v[8*size-1]) v = v | ~mask;
      if (xlen == 32) begin
         v[63:32]    = '0;
         wexp[63:32] = '0;
      end
      dexp = v;
   endfunction

   always @(negedge clk) begin
      if (m_rsp_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_rsp_valid", 64'd1, 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("rsp_cycle", cyc, mon_e.cyc);
            chk("rsp_err", 64'(m_rsp_err), 64'(mon_e.err));
            chk("rsp_data", m_rsp_data, mon_e.data);
            chk("rsp_we", 64'(m_rsp_we), 64'(mon_e.we));
            chk("rsp_rd", 64'(m_rsp_rd), 64'(mon_e.rd));
         end
      end
   end

   task automatic do_op(input bit st, input logic [2:0] f3, input logic [63:0] base,
                        input logic [11:0] off, input logic [63:0] wd, input logic [4:0] rd,
                        input int gdly, input int rvdly, input logic [63:0] rdata);
      logic [1:0]  e;
      logic [31:0] addr;
      logic [7:0]  be;
      logic [63:0] wexp, dexp, cg;
      model(xlen_cur, st, f3, base, off, wd, rdata, e, addr, be, wexp, dexp);
      req_store = st; req_funct3 = f3; req_base = base; req_offset = off;
      req_wdata = wd; req_rd = rd; req_valid = 1'b1;
      chk("req_ready_idle", 64'(m_req_ready), 64'd1);
      if (e != 2'b00) push_rsp(e, 64'd0, 1'b0, rd, cyc + 64'd1);
      @(negedge clk);
      req_valid = 1'b0;
      req_base = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
      req_funct3 = 3'($urandom_range(7)); req_store = 1'($urandom_range(1));
      if (e != 2'b00) begin
         chk("err_no_mem_req", 64'(m_mem_req), 64'd0);
      end else begin
         for (int k = 0; k <= gdly; k++) begin
            chk("mem_req", 64'(m_mem_req), 64'd1);
            chk("mem_we", 64'(m_mem_we), 64'(st));
            chk("mem_addr", 64'(m_mem_addr), 64'(addr));
            chk("mem_be", 64'(m_mem_be), 64'(be));
            chk("mem_wdata", m_mem_wdata, wexp);
            chk("req_ready_busy", 64'(m_req_ready), 64'd0);
            if (k == gdly) begin
               mem_gnt = 1'b1;
               cg = cyc;
               if (st) push_rsp(2'b00, 64'd0, 1'b0, rd, cg + 64'd1);
               else if (rvdly >= tmo_cur) push_rsp(2'b11, 64'd0, 1'b0, rd, cg + 64'(1 + tmo_cur));
               else push_rsp(2'b00, dexp, rd != 5'd0, rd, cg + 64'(2 + rvdly));
            end else begin
               mem_gnt = 1'b0;
            end
            mem_rvalid = 1'($urandom_range(1));
            mem_rdata  = {$urandom, $urandom};
            @(negedge clk);
         end
         mem_gnt = 1'b0; mem_rvalid = 1'b0;
         if (!st) begin
            for (int k = 0; k < tmo_cur; k++) begin
               mem_rvalid = (k == rvdly);
               mem_rdata  = (k == rvdly) ? rdata : {$urandom, $urandom};
               mem_gnt    = 1'($urandom_range(1));
               @(negedge clk);
               if (k == rvdly) break;
            end
            mem_rvalid = 1'b0; mem_gnt = 1'b0;
         end
      end
      for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
      chk("rsp_outstanding", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      @(negedge clk);
   endtask

   task automatic rand_ops(input int n);
      bit          st;
      logic [2:0]  f3;
      logic [63:0] base;
      logic [11:0] off;
      int          lo;
      for (int i = 0; i < n; i++) begin
         st   = 1'($urandom_range(1));
         f3   = 3'($urandom_range(7));
         base = {$urandom, $urandom};
         off  = 12'($urandom_range(4095));
         if ($urandom_range(3) != 0) begin
            lo = ($urandom_range(7) >> f3[1:0]) << f3[1:0];
            base[2:0] = 3'd0;
            off[2:0]  = 3'(lo);
         end
         do_op(st, f3, base, off, {$urandom, $urandom}, 5'($urandom_range(31)),
               $urandom_range(3), $urandom_range(tmo_cur), {$urandom, $urandom});
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      nrst_a = 1'b0; nrst_b = 1'b0; phase = 1'b0; xlen_cur = 32; tmo_cur = 4;
      req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0; req_base = '0; req_offset = '0;
      req_wdata = '0; req_rd = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      repeat (3) @(negedge clk);
      chk("reset_req_ready", 64'(m_req_ready), 64'd1);
      chk("reset_mem_req", 64'(m_mem_req), 64'd0);
      chk("reset_mem_be", 64'(m_mem_be), 64'd0);
      chk("reset_rsp_valid", 64'(m_rsp_valid), 64'd0);
      nrst_a = 1'b1;
      @(negedge clk);

      do_op(1'b0, 3'b000, 64'h100, 12'h003, 64'h0, 5'd5, 0, 0, 64'h80FF_1234);
      do_op(1'b1, 3'b001, 64'h200, 12'hFFE, 64'hDEAD_BEEF, 5'd3, 0, 0, 64'h0);
      do_op(1'b0, 3'b010, 64'h101, 12'h000, 64'h0, 5'd4, 0, 0, 64'h0);
      do_op(1'b0, 3'b010, 64'h400, 12'h000, 64'h0, 5'd6, 0, 4, 64'h1234_5678);
      do_op(1'b0, 3'b010, 64'h400, 12'h004, 64'h0, 5'd6, 1, 3, 64'hCAFE_F00D);
      do_op(1'b0, 3'b011, 64'h400, 12'h000, 64'h0, 5'd1, 0, 0, 64'h0);
      do_op(1'b1, 3'b100, 64'h400, 12'h000, 64'h0, 5'd1, 0, 0, 64'h0);
      do_op(1'b0, 3'b101, 64'h402, 12'h000, 64'h0, 5'd0, 2, 1, 64'h9ABC_0000);

      // Stall in REQ, then abandon the access with a one-cycle reset.
      req_store = 1'b0; req_funct3 = 3'b010; req_base = 64'h300; req_offset = '0;
      req_rd = 5'd7; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      for (int k = 0; k < 10; k++) begin
         chk("stall_mem_req", 64'(m_mem_req), 64'd1);
         chk("stall_mem_addr", 64'(m_mem_addr), 64'h300);
         chk("stall_mem_be", 64'(m_mem_be), 64'hF);
         chk("stall_req_ready", 64'(m_req_ready), 64'd0);
         @(negedge clk);
      end
      nrst_a = 1'b0;
      @(negedge clk);
      nrst_a = 1'b1;
      chk("post_reset_ready", 64'(m_req_ready), 64'd1);
      chk("post_reset_mem_req", 64'(m_mem_req), 64'd0);
      repeat (6) @(negedge clk);

      rand_ops(60);

      nrst_a = 1'b0; phase = 1'b1; xlen_cur = 64; tmo_cur = 15;
      repeat (2) @(negedge clk);
      nrst_b = 1'b1;
      @(negedge clk);
      do_op(1'b0, 3'b110, 64'h1000, 12'h004, 64'h0, 5'd9, 0, 0, 64'h8765_4321_0000_0000);
      do_op(1'b0, 3'b011, 64'h2000, 12'h008, 64'h0, 5'd2, 1, 2, 64'hFEDC_BA98_7654_3210);
      do_op(1'b1, 3'b011, 64'h2000, 12'h000, 64'h0123_4567_89AB_CDEF, 5'd2, 0, 0, 64'h0);
      do_op(1'b0, 3'b010, 64'h2006, 12'h000, 64'h0, 5'd2, 0, 0, 64'h0);
      do_op(1'b0, 3'b010, 64'h2004, 12'h000, 64'h0, 5'd8, 0, 15, 64'h0);
      do_op(1'b0, 3'b010, 64'h2004, 12'h000, 64'h0, 5'd8, 0, 14, 64'hF000_0001_0000_0000);
      rand_ops(60);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
